// File: rtl/regfile_mp.sv
// Multi-port register file: one write port, NRD independent read ports.
// Read path is either combinational or registered (1-cycle latency) per build.
// Optional same-cycle write-to-read forwarding and a hardwired-zero entry 0.
// A clear engine sweeps the array to zero, one entry per cycle, on request;
// writes arriving while the sweep runs are discarded and flagged on wr_drop.

module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int READ_REG = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [WIDTH-1:0]      wdata,
    output logic                  wr_drop,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*WIDTH-1:0]  rdata,
    output logic [NRD-1:0]        rd_valid,
    input  logic                  clr,
    output logic                  busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_e              state_q;
    state_e              state_d;
    logic [ADDR_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]   cnt_d;
    logic                busy_s;
    logic                sweep_last_s;
    logic                zero_wr_s;
    logic                wr_ok_s;
    logic                wr_drop_q;
    logic                wr_drop_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------

    // Clear FSM state and sweep counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: start on clr from IDLE, walk every entry once, then return
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sweep_last_s = (cnt_q == LAST_IDX);
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q;
                end
            end
            ST_SWEEP: begin
                // clr is deliberately not looked at here: no restart mid-sweep
                cnt_d = cnt_q + ADDR_W'(1);
                if (sweep_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SWEEP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: busy is a pure decode of the state flop, so it is glitch-free
    always_comb begin
        case (state_q)
            ST_SWEEP: busy_s = 1'b1;
            ST_IDLE:  busy_s = 1'b0;
            default:  busy_s = 1'b0;
        endcase
    end

    assign busy = busy_s;

    // ------------------------------------------------------------------
    // Write port and storage
    // ------------------------------------------------------------------

    // Write qualification: blocked by the sweep, and silently by the zero entry
    always_comb begin
        zero_wr_s = (ZERO_REG != 0) && (waddr == '0);
        wr_ok_s   = we && !busy_s && !zero_wr_s;
        wr_drop_d = we && busy_s;
    end

    // Dropped-write flag: one-cycle pulse after a write hits a busy array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
        end
    end

    assign wr_drop = wr_drop_q;

    // Storage array: sweep clear has priority, otherwise a qualified write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (busy_s && (cnt_q == ADDR_W'(e))) begin
                    mem_q[e] <= '0;
                end else if (wr_ok_s && (waddr == ADDR_W'(e))) begin
                    mem_q[e] <= wdata;
                end else begin
                    mem_q[e] <= mem_q[e];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic              zero_hit_s;
        logic [WIDTH-1:0]  arr_s;

        assign ra_s = raddr[p*ADDR_W +: ADDR_W];

        // Array lookup; the zero entry is forced here so every path sees it
        always_comb begin
            zero_hit_s = (ZERO_REG != 0) && (ra_s == '0);
            if (zero_hit_s) begin
                arr_s = '0;
            end else begin
                arr_s = mem_q[ra_s];
            end
        end

        if (READ_REG != 0) begin : g_reg
            logic [WIDTH-1:0] rdata_q;
            logic [WIDTH-1:0] rdata_d;
            logic             valid_q;
            logic             byp_s;

            // Forward same-edge write data; never during a sweep or to entry 0
            always_comb begin
                byp_s = (BYPASS != 0) && we && !busy_s &&
                        (ra_s == waddr) && !zero_hit_s;
                if (!rd_en[p]) begin
                    rdata_d = rdata_q;
                end else if (byp_s) begin
                    rdata_d = wdata;
                end else begin
                    rdata_d = arr_s;
                end
            end

            // Registered read data and valid; data holds while the port idles
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q <= '0;
                    valid_q <= 1'b0;
                end else begin
                    rdata_q <= rdata_d;
                    valid_q <= rd_en[p];
                end
            end

            assign rdata[p*WIDTH +: WIDTH] = rdata_q;
            assign rd_valid[p]             = valid_q;
        end else begin : g_comb
            assign rdata[p*WIDTH +: WIDTH] = arr_s;
            assign rd_valid[p]             = rd_en[p];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three builds share one stimulus stream.
//   dut_a: registered read, bypass, zero entry
//   dut_b: registered read, no bypass, no zero entry
//   dut_c: combinational read, zero entry
// A behavioural model predicts read data when a read is driven; predictions
// are queued and compared once the registered outputs appear.

module tb_regfile_mp;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [W-1:0]    wdata;
    logic [NR-1:0]   rd_en;
    logic [NR*AW-1:0] raddr;
    logic            clr;

    logic            wr_drop_a, wr_drop_b, wr_drop_c;
    logic            busy_a, busy_b, busy_c;
    logic [NR*W-1:0] rdata_a, rdata_b, rdata_c;
    logic [NR-1:0]   rd_valid_a, rd_valid_b, rd_valid_c;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .NRD(NR),
                 .READ_REG(1), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .wr_drop(wr_drop_a), .rd_en(rd_en), .raddr(raddr), .rdata(rdata_a),
        .rd_valid(rd_valid_a), .clr(clr), .busy(busy_a));

    regfile_mp #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .NRD(NR),
                 .READ_REG(1), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .wr_drop(wr_drop_b), .rd_en(rd_en), .raddr(raddr), .rdata(rdata_b),
        .rd_valid(rd_valid_b), .clr(clr), .busy(busy_b));

    regfile_mp #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .NRD(NR),
                 .READ_REG(0), .BYPASS(0), .ZERO_REG(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .wr_drop(wr_drop_c), .rd_en(rd_en), .raddr(raddr), .rdata(rdata_c),
        .rd_valid(rd_valid_c), .clr(clr), .busy(busy_c));

    typedef struct {
        int         port;
        int         addr;
        logic [W-1:0] da;
        logic [W-1:0] db;
    } rd_exp_t;

    rd_exp_t       sb[$];
    logic [W-1:0]  ma [D];
    logic [W-1:0]  mb [D];
    bit            m_busy;
    int            m_cnt;
    bit            m_drop;
    int            n_pass  = 0;
    int            n_total = 0;

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            ma[i] = '0;
            mb[i] = '0;
        end
        m_busy = 1'b0;
        m_cnt  = 0;
        m_drop = 1'b0;
        sb.delete();
    endtask

    task automatic set_raddr(input int p, input int a);
        raddr[p*AW +: AW] = AW'(a);
    endtask

    // Predict enabled reads, advance one edge, update the model, settle
    task automatic clk_step();
        rd_exp_t e;
        logic [AW-1:0] ra;
        for (int p = 0; p < NR; p++) begin
            if (rd_en[p]) begin
                ra     = raddr[p*AW +: AW];
                e.port = p;
                e.addr = int'(ra);
                if (ra == '0)                          e.da = '0;
                else if (!m_busy && we && ra == waddr) e.da = wdata;
                else                                   e.da = ma[ra];
                e.db = mb[ra];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        m_drop = we && m_busy;
        if (m_busy) begin
            ma[m_cnt] = '0;
            mb[m_cnt] = '0;
            if (m_cnt == D - 1) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            if (we) begin
                if (waddr != '0) ma[waddr] = wdata;
                mb[waddr] = wdata;
            end
            if (clr) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rd_exp_t e;
        rst_n = 1'b0;
        we = 1'b0; clr = 1'b0; rd_en = '0; raddr = '0; waddr = '0; wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total += 5;
        if (busy_a !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy_a); else n_pass++;
        if (wr_drop_a !== 1'b0) $display("FAIL reset_wr_drop got=%b exp=0", wr_drop_a); else n_pass++;
        if (rd_valid_a !== 2'b00) $display("FAIL reset_rd_valid got=%b exp=00", rd_valid_a); else n_pass++;
        if (rdata_a !== 64'h0) $display("FAIL reset_rdata_a got=%h exp=0", rdata_a); else n_pass++;
        if (rdata_b !== 64'h0) $display("FAIL reset_rdata_b got=%h exp=0", rdata_b); else n_pass++;
        rst_n = 1'b1;
        for (int a = 0; a < D; a++) begin
            rd_en = 2'b01;
            set_raddr(0, a);
            clk_step();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_total += 3;
                if (rdata_a[e.port*W +: W] !== e.da) $display("FAIL reset_read_a addr=%0d got=%h exp=%h", e.addr, rdata_a[e.port*W +: W], e.da); else n_pass++;
                if (rdata_b[e.port*W +: W] !== e.db) $display("FAIL reset_read_b addr=%0d got=%h exp=%h", e.addr, rdata_b[e.port*W +: W], e.db); else n_pass++;
                if (rd_valid_a[e.port] !== 1'b1) $display("FAIL reset_valid addr=%0d got=%b exp=1", e.addr, rd_valid_a[e.port]); else n_pass++;
            end
        end
        rd_en = 2'b00;
        clk_step();
        n_total += 2;
        if (rd_valid_a !== 2'b00) $display("FAIL reset_valid_drop_a got=%b exp=00", rd_valid_a); else n_pass++;
        if (rd_valid_b !== 2'b00) $display("FAIL reset_valid_drop_b got=%b exp=00", rd_valid_b); else n_pass++;
    endtask

    task automatic test_write_read();
        rd_exp_t e;
        logic [W-1:0] last_p0;
        last_p0 = '0;
        we = 1'b1; waddr = 5'd5;  wdata = 32'hDEADBEEF; rd_en = 2'b00;
        clk_step();
        waddr = 5'd31; wdata = 32'h12345678;
        clk_step();
        we = 1'b0; rd_en = 2'b11;
        set_raddr(0, 5);
        set_raddr(1, 31);
        clk_step();
        n_total += 2;
        if (rdata_a[0 +: W] !== 32'hDEADBEEF) $display("FAIL wr_rd_p0 got=%h exp=deadbeef", rdata_a[0 +: W]); else n_pass++;
        if (rdata_a[W +: W] !== 32'h12345678) $display("FAIL wr_rd_p1 got=%h exp=12345678", rdata_a[W +: W]); else n_pass++;
        sb.delete();
        rd_en = 2'b00;
        clk_step();
        n_total += 2;
        if (rdata_a[0 +: W] !== 32'hDEADBEEF) $display("FAIL wr_rd_hold got=%h exp=deadbeef", rdata_a[0 +: W]); else n_pass++;
        if (rd_valid_a !== 2'b00) $display("FAIL wr_rd_valid_idle got=%b exp=00", rd_valid_a); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            we    = 1'b1;
            waddr = AW'($urandom_range(8, 31));
            wdata = $urandom;
            rd_en = 2'b11;
            set_raddr(0, (i % 3 == 0) ? int'(waddr) : int'($urandom_range(0, 31)));
            set_raddr(1, (i % 2 == 0) ? int'(raddr[0 +: AW]) : int'($urandom_range(0, 31)));
            clk_step();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_total += 3;
                if (rdata_a[e.port*W +: W] !== e.da) $display("FAIL wr_rd_rand_a port=%0d addr=%0d got=%h exp=%h", e.port, e.addr, rdata_a[e.port*W +: W], e.da); else n_pass++;
                if (rdata_b[e.port*W +: W] !== e.db) $display("FAIL wr_rd_rand_b port=%0d addr=%0d got=%h exp=%h", e.port, e.addr, rdata_b[e.port*W +: W], e.db); else n_pass++;
                if (rd_valid_a[e.port] !== 1'b1) $display("FAIL wr_rd_rand_valid port=%0d got=%b exp=1", e.port, rd_valid_a[e.port]); else n_pass++;
                if (e.port == 0) last_p0 = e.da;
            end
        end
        we = 1'b0; rd_en = 2'b00;
        clk_step();
        n_total += 1;
        if (rdata_a[0 +: W] !== last_p0) $display("FAIL wr_rd_rand_hold got=%h exp=%h", rdata_a[0 +: W], last_p0); else n_pass++;
    endtask

    task automatic test_comb();
        rd_exp_t e;
        logic [W-1:0] old5;
        we = 1'b0; rd_en = 2'b10;
        set_raddr(0, 5);
        set_raddr(1, 31);
        #1;
        n_total += 3;
        if (rdata_c[0 +: W] !== ma[5]) $display("FAIL comb_p0 got=%h exp=%h", rdata_c[0 +: W], ma[5]); else n_pass++;
        if (rdata_c[W +: W] !== ma[31]) $display("FAIL comb_p1 got=%h exp=%h", rdata_c[W +: W], ma[31]); else n_pass++;
        if (rd_valid_c !== 2'b10) $display("FAIL comb_valid got=%b exp=10", rd_valid_c); else n_pass++;
        old5  = ma[5];
        we    = 1'b1; waddr = 5'd5; wdata = 32'h0BADF00D;
        #1;
        n_total += 1;
        if (rdata_c[0 +: W] !== old5) $display("FAIL comb_same_cycle got=%h exp=%h", rdata_c[0 +: W], old5); else n_pass++;
        clk_step();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_total += 2;
            if (rdata_a[e.port*W +: W] !== e.da) $display("FAIL comb_side_a addr=%0d got=%h exp=%h", e.addr, rdata_a[e.port*W +: W], e.da); else n_pass++;
            if (rdata_b[e.port*W +: W] !== e.db) $display("FAIL comb_side_b addr=%0d got=%h exp=%h", e.addr, rdata_b[e.port*W +: W], e.db); else n_pass++;
        end
        we = 1'b0;
        set_raddr(1, 0);
        #1;
        n_total += 2;
        if (rdata_c[0 +: W] !== 32'h0BADF00D) $display("FAIL comb_after_write got=%h exp=0badf00d", rdata_c[0 +: W]); else n_pass++;
        if (rdata_c[W +: W] !== 32'h0) $display("FAIL comb_zero got=%h exp=0", rdata_c[W +: W]); else n_pass++;
        rd_en = 2'b00;
    endtask

    task automatic test_bypass();
        rd_exp_t e;
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        rd_en = 2'b10;
        set_raddr(1, 7);
        clk_step();
        n_total += 2;
        if (rdata_a[W +: W] !== 32'hA5A5A5A5) $display("FAIL bypass_on got=%h exp=a5a5a5a5", rdata_a[W +: W]); else n_pass++;
        if (rdata_b[W +: W] !== 32'h0) $display("FAIL bypass_off got=%h exp=0", rdata_b[W +: W]); else n_pass++;
        sb.delete();
        we = 1'b0; rd_en = 2'b11;
        set_raddr(0, 7);
        clk_step();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_total += 2;
            if (rdata_a[e.port*W +: W] !== e.da) $display("FAIL bypass_after_a port=%0d got=%h exp=%h", e.port, rdata_a[e.port*W +: W], e.da); else n_pass++;
            if (rdata_b[e.port*W +: W] !== e.db) $display("FAIL bypass_after_b port=%0d got=%h exp=%h", e.port, rdata_b[e.port*W +: W], e.db); else n_pass++;
        end
        rd_en = 2'b00;
    endtask

    task automatic test_zero();
        rd_exp_t e;
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        rd_en = 2'b01;
        set_raddr(0, 0);
        clk_step();
        n_total += 2;
        if (rdata_a[0 +: W] !== 32'h0) $display("FAIL zero_same_edge got=%h exp=0", rdata_a[0 +: W]); else n_pass++;
        if (wr_drop_a !== 1'b0) $display("FAIL zero_wr_drop got=%b exp=0", wr_drop_a); else n_pass++;
        sb.delete();
        we = 1'b0; rd_en = 2'b11;
        set_raddr(1, 0);
        clk_step();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_total += 2;
            if (rdata_a[e.port*W +: W] !== e.da) $display("FAIL zero_read_a port=%0d got=%h exp=%h", e.port, rdata_a[e.port*W +: W], e.da); else n_pass++;
            if (rdata_b[e.port*W +: W] !== e.db) $display("FAIL zero_read_b port=%0d got=%h exp=%h", e.port, rdata_b[e.port*W +: W], e.db); else n_pass++;
        end
        n_total += 2;
        if (rdata_b[0 +: W] !== 32'hFFFFFFFF) $display("FAIL zero_off got=%h exp=ffffffff", rdata_b[0 +: W]); else n_pass++;
        if (rdata_a[W +: W] !== 32'h0) $display("FAIL zero_on got=%h exp=0", rdata_a[W +: W]); else n_pass++;
        rd_en = 2'b00;
    endtask

    task automatic test_clear();
        rd_exp_t e;
        int busy_cnt;
        for (int i = 0; i < D; i++) begin
            we = 1'b1; waddr = AW'(i); wdata = W'(i); rd_en = 2'b00;
            clk_step();
        end
        we  = 1'b0;
        clr = 1'b1;
        clk_step();
        clr = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy_a !== 1'b1) break;
            busy_cnt++;
            n_total += 1;
            if (busy_a !== m_busy) $display("FAIL clr_busy k=%0d got=%b exp=%b", k, busy_a, m_busy); else n_pass++;
            we    = (k == 10);
            waddr = 5'd3;
            wdata = 32'h00000077;
            clr   = (k == 15);
            rd_en = (k == 5) ? 2'b01 : 2'b00;
            set_raddr(0, 20);
            clk_step();
            n_total += 1;
            if (wr_drop_a !== (k == 10)) $display("FAIL clr_wr_drop k=%0d got=%b exp=%b", k, wr_drop_a, (k == 10)); else n_pass++;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_total += 2;
                if (rdata_a[e.port*W +: W] !== e.da) $display("FAIL clr_mid_read k=%0d got=%h exp=%h", k, rdata_a[e.port*W +: W], e.da); else n_pass++;
                if (rdata_a[e.port*W +: W] !== 32'd20) $display("FAIL clr_mid_read20 k=%0d got=%h exp=14", k, rdata_a[e.port*W +: W]); else n_pass++;
            end
        end
        we = 1'b0; clr = 1'b0;
        n_total += 1;
        if (busy_cnt !== 32) $display("FAIL clr_busy_len got=%0d exp=32", busy_cnt); else n_pass++;
        for (int a = 0; a < D; a += 2) begin
            rd_en = 2'b11;
            set_raddr(0, a);
            set_raddr(1, a + 1);
            clk_step();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_total += 2;
                if (rdata_a[e.port*W +: W] !== 32'h0) $display("FAIL clr_after_a addr=%0d got=%h exp=0", e.addr, rdata_a[e.port*W +: W]); else n_pass++;
                if (rdata_b[e.port*W +: W] !== e.db) $display("FAIL clr_after_b addr=%0d got=%h exp=%h", e.addr, rdata_b[e.port*W +: W], e.db); else n_pass++;
            end
        end
        rd_en = 2'b00;
    endtask

    task automatic test_reset_mid_sweep();
        rd_exp_t e;
        int busy_cnt;
        we = 1'b1; waddr = 5'd1; wdata = 32'h11111111;
        clk_step();
        we  = 1'b0;
        clr = 1'b1;
        clk_step();
        clr = 1'b0;
        repeat (12) clk_step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total += 3;
        if (busy_a !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy_a); else n_pass++;
        if (busy_b !== 1'b0) $display("FAIL rst_mid_busy_b got=%b exp=0", busy_b); else n_pass++;
        if (rdata_a !== 64'h0) $display("FAIL rst_mid_rdata got=%h exp=0", rdata_a); else n_pass++;
        rd_en = 2'b01;
        for (int a = 0; a < D; a++) begin
            set_raddr(0, a);
            #1;
            n_total += 1;
            if (rdata_c[0 +: W] !== 32'h0) $display("FAIL rst_mid_comb addr=%0d got=%h exp=0", a, rdata_c[0 +: W]); else n_pass++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < D; a += 2) begin
            rd_en = 2'b11;
            set_raddr(0, a);
            set_raddr(1, a + 1);
            clk_step();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_total += 2;
                if (rdata_a[e.port*W +: W] !== 32'h0) $display("FAIL rst_mid_read_a addr=%0d got=%h exp=0", e.addr, rdata_a[e.port*W +: W]); else n_pass++;
                if (rdata_b[e.port*W +: W] !== 32'h0) $display("FAIL rst_mid_read_b addr=%0d got=%h exp=0", e.addr, rdata_b[e.port*W +: W]); else n_pass++;
            end
        end
        rd_en = 2'b00;
        we = 1'b1; waddr = 5'd1; wdata = 32'h22222222;
        clk_step();
        clr = 1'b1; waddr = 5'd9; wdata = 32'h99999999;
        clk_step();
        clr = 1'b0; we = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy_a !== 1'b1) break;
            busy_cnt++;
            rd_en = 2'b11;
            set_raddr(0, 9);
            set_raddr(1, 1);
            clk_step();
            while (sb.size() > 0) begin
                e = sb.pop_front();
                n_total += 2;
                if (rdata_a[e.port*W +: W] !== e.da) $display("FAIL resweep_a k=%0d addr=%0d got=%h exp=%h", k, e.addr, rdata_a[e.port*W +: W], e.da); else n_pass++;
                if (rdata_b[e.port*W +: W] !== e.db) $display("FAIL resweep_b k=%0d addr=%0d got=%h exp=%h", k, e.addr, rdata_b[e.port*W +: W], e.db); else n_pass++;
            end
            if (k == 1) begin
                n_total += 1;
                if (rdata_a[W +: W] !== 32'h22222222) $display("FAIL resweep_entry1_k1 got=%h exp=22222222", rdata_a[W +: W]); else n_pass++;
            end
            if (k == 2) begin
                n_total += 1;
                if (rdata_a[W +: W] !== 32'h0) $display("FAIL resweep_entry1_k2 got=%h exp=0", rdata_a[W +: W]); else n_pass++;
            end
        end
        rd_en = 2'b00;
        n_total += 1;
        if (busy_cnt !== 32) $display("FAIL resweep_busy_len got=%0d exp=32", busy_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_comb();
        test_bypass();
        test_zero();
        test_clear();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
